// File: rtl/ysyx_22040088_lsu.sv
// ----------------------------------------------------------------------------
// ysyx_22040088_lsu
//
// Load/store unit that sits after decode. It takes the decoder's memory
// controls, the ALU address and the rs2 store data, and runs one ready/valid
// transaction on the data-memory bus. It returns either an extended load
// result or a store completion. Only one transaction is outstanding at a
// time; busy stalls the pipeline until the response pulse has been sent.
//
// Optional build macro:
//   YSYX_22040088_LSU_TIMEOUT_EN - adds a watchdog. If REQ+WAIT lasts
//   TIMEOUT_CYCLES cycles, the unit completes with resp_err=1.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   req_valid/req_ready request handshake (mem_ena / unit idle)
//   mem_wen             1=store, 0=load
//   mem_mask            one-hot size: 0001 dword, 0010 word, 0100 half, 1000 byte
//   sel_rfres           bit2 zero-extend, bit1 sign-extend, bit0 non-load
//   addr, wdata         byte address, LSB-aligned store data
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load data (0 for stores and errors)
//   resp_err            misaligned access or watchdog timeout
//   busy                state != IDLE
//   dmem_*              aligned 8-byte data-memory bus
// ----------------------------------------------------------------------------
module ysyx_22040088_lsu #(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            mem_wen,
  input  logic [3:0]      mem_mask,
  input  logic [2:0]      sel_rfres,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            busy,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_addr,
  output logic            dmem_wen,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_wstrb,
  input  logic            dmem_resp_valid,
  input  logic [XLEN-1:0] dmem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

  state_e          state_q, state_d;
  size_e           size_q, size_d;
  logic            wen_q, wen_d;
  logic            sext_q, sext_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  // Zero-extension is the fallback whenever sign-extension is not asked
  // for, so bit2 and the non-load flag carry no extra information here.
  logic unused_sel;
  assign unused_sel = sel_rfres[2] ^ sel_rfres[0];

  // Lowest set mask bit wins, so multi-hot masks pick the widest size.
  size_e req_size;
  always_comb begin
    if (mem_mask[0])      req_size = SZ_D;
    else if (mem_mask[1]) req_size = SZ_W;
    else if (mem_mask[2]) req_size = SZ_H;
    else                  req_size = SZ_B;
  end

  logic req_misal;
  always_comb begin
    case (req_size)
      SZ_H:    req_misal = addr[0];
      SZ_W:    req_misal = |addr[1:0];
      SZ_D:    req_misal = |addr[2:0];
      default: req_misal = 1'b0;
    endcase
  end

  // Load extraction: shift the addressed bytes down to bit 0, then extend.
  logic [2:0]      off;
  logic [5:0]      bit_sh;
  logic [XLEN-1:0] rd_shift;
  logic [XLEN-1:0] load_ext;
  assign off      = addr_q[2:0];
  assign bit_sh   = {off, 3'b000};
  assign rd_shift = dmem_rdata >> bit_sh;

  always_comb begin
    case (size_q)
      SZ_B:    load_ext = sext_q ? {{(XLEN-8){rd_shift[7]}},   rd_shift[7:0]}
                                 : {{(XLEN-8){1'b0}},          rd_shift[7:0]};
      SZ_H:    load_ext = sext_q ? {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]}
                                 : {{(XLEN-16){1'b0}},         rd_shift[15:0]};
      SZ_W:    load_ext = sext_q ? {{(XLEN-32){rd_shift[31]}}, rd_shift[31:0]}
                                 : {{(XLEN-32){1'b0}},         rd_shift[31:0]};
      default: load_ext = rd_shift;
    endcase
  end

  // Byte strobes for stores; dword always covers the whole beat.
  logic [7:0] st_strb;
  always_comb begin
    case (size_q)
      SZ_B:    st_strb = 8'h01 << off;
      SZ_H:    st_strb = 8'h03 << off;
      SZ_W:    st_strb = 8'h0F << off;
      default: st_strb = 8'hFF;
    endcase
  end

`ifdef YSYX_22040088_LSU_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout;

  // The counter sits at zero in IDLE, so it is clear on REQ entry; it counts
  // each REQ/WAIT cycle, and the cycle that holds TIMEOUT_CYCLES-1 is the
  // last one spent waiting.
  assign timeout = (state_q == S_REQ || state_q == S_WAIT) &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == S_REQ || state_q == S_WAIT) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  logic timeout;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    wen_d   = wen_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          size_d  = req_size;
          wen_d   = mem_wen;
          sext_d  = sel_rfres[1];
          addr_d  = addr;
          wdata_d = wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          // An empty mask completes without touching the bus.
          if (mem_mask == 4'b0000) begin
            state_d = S_RESP;
          end else if (req_misal) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (dmem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dmem_resp_valid) begin
          rdata_d = wen_q ? '0 : load_ext;
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A real response in WAIT takes priority over the watchdog.
    if (timeout && !(state_q == S_WAIT && dmem_resp_valid)) begin
      rdata_d = '0;
      err_d   = 1'b1;
      state_d = S_RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      size_q  <= SZ_B;
      wen_q   <= 1'b0;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      wen_q   <= wen_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // The bus fields come from latched state only, so they stay stable
  // while REQ is stalled by dmem_req_ready.
  logic in_req, in_resp;
  assign in_req  = (state_q == S_REQ);
  assign in_resp = (state_q == S_RESP);

  assign req_ready      = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign resp_valid     = in_resp;
  assign resp_err       = in_resp & err_q;
  assign resp_rdata     = in_resp ? rdata_q : '0;
  assign dmem_req_valid = in_req;
  assign dmem_addr      = in_req ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign dmem_wen       = in_req & wen_q;
  assign dmem_wdata     = (in_req && wen_q) ? (wdata_q << bit_sh) : '0;
  assign dmem_wstrb     = (in_req && wen_q) ? st_strb : 8'h00;

endmodule
